// File: rtl/wb_uart_pkg.sv
// Shared constants and state types for the Wishbone UART.
package wb_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_RX_VALID   = 2;
  localparam int unsigned ST_RX_FULL    = 3;
  localparam int unsigned ST_RX_OVERRUN = 4;
  localparam int unsigned ST_TX_BUSY    = 5;
  localparam int unsigned ST_FRAME_ERR  = 6;
  localparam int unsigned ST_TX_OVF     = 7;

  localparam int unsigned DEFAULT_DIV_C = 868;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus bundle shared by interconnect and slaves.
interface wb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (input clk, rst, rdata, ack, err, stall,
                  output cyc, stb, we, adr, sel, wdata);
  modport slave  (input clk, rst, cyc, stb, we, adr, sel, wdata,
                  output rdata, ack, err, stall);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; push ignored when full, pop when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart.sv
// Wishbone B4 pipelined 8N1 UART: zero-stall slave, single-cycle ack, TX/RX FIFOs.
module wb_uart
  import wb_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  wb,
  output logic txd,
  input  logic rxd,
  output logic irq
);
  logic                 acc, wr_data, rd_data, wr_status, wr_div, wr_ctrl;
  logic [1:0]           reg_sel;
  logic [DIV_WIDTH-1:0] div_q, eff_div;
  logic [1:0]           ctrl_q;
  logic                 rx_overrun, frame_err, tx_ovf;
  logic [7:0]           status, w1c;
  logic [31:0]          rd_val, rdata_q;
  logic                 ack_q, irq_q, unused_bits;
  logic                 tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push;
  logic [7:0]           tx_head, rx_head;
  logic                 rx_ovr_set, fe_set;

  tx_state_t            tx_state, tx_next;
  logic [DIV_WIDTH-1:0] tx_timer;
  logic [7:0]           tx_shift;
  logic [2:0]           tx_bits;
  logic                 tx_bound, tx_busy, txd_q;

  rx_state_t            rx_state, rx_next;
  logic [DIV_WIDTH-1:0] rx_timer;
  logic [7:0]           rx_shift;
  logic [2:0]           rx_bits;
  logic                 rx_bound, rx_s1, rx_s2, rx_prev;

  assign acc       = wb.cyc & wb.stb;
  assign reg_sel   = wb.adr[3:2];
  assign wr_data   = acc & wb.we & (reg_sel == REG_DATA) & wb.sel[0];
  assign rd_data   = acc & ~wb.we & (reg_sel == REG_DATA);
  assign wr_status = acc & wb.we & (reg_sel == REG_STATUS) & wb.sel[0];
  assign wr_div    = acc & wb.we & (reg_sel == REG_DIV);
  assign wr_ctrl   = acc & wb.we & (reg_sel == REG_CTRL) & wb.sel[0];
  assign w1c       = wr_status ? wb.wdata[7:0] : '0;
  assign eff_div   = (div_q < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : div_q;
  assign tx_busy   = (tx_state != TX_IDLE);
  assign tx_bound  = (tx_timer == '0);
  assign rx_bound  = (rx_timer == '0);
  assign unused_bits = ^{wb.clk, wb.rst, wb.adr, wb.wdata, wb.sel};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(wr_data), .pop(tx_pop), .wdata(wb.wdata[7:0]),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rd_data), .wdata(rx_shift),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty));

  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_RX_VALID]   = ~rx_empty;
    status[ST_RX_FULL]    = rx_full;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_TX_BUSY]    = tx_busy;
    status[ST_FRAME_ERR]  = frame_err;
    status[ST_TX_OVF]     = tx_ovf;
    rd_val = '0;
    case (reg_sel)
      REG_DATA:   if (!rx_empty) rd_val[7:0] = rx_head;
      REG_STATUS: rd_val[7:0] = status;
      REG_DIV:    rd_val[DIV_WIDTH-1:0] = div_q;
      REG_CTRL:   rd_val[1:0] = ctrl_q;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      div_q      <= DIV_WIDTH'(DEFAULT_DIV);
      ctrl_q     <= '0;
      tx_ovf     <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ack_q   <= acc;
      rdata_q <= (acc & ~wb.we) ? rd_val : '0;
      if (wr_div) begin
        for (int unsigned i = 0; i < DIV_WIDTH; i++)
          if (wb.sel[i/8]) div_q[i] <= wb.wdata[i];
      end
      if (wr_ctrl) ctrl_q <= wb.wdata[1:0];
      // A set in the same cycle as its write-1-to-clear must win.
      tx_ovf     <= (wr_data & tx_full) | (tx_ovf & ~w1c[ST_TX_OVF]);
      rx_overrun <= rx_ovr_set | (rx_overrun & ~w1c[ST_RX_OVERRUN]);
      frame_err  <= fe_set | (frame_err & ~w1c[ST_FRAME_ERR]);
      irq_q      <= (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty & ~tx_busy);
    end
  end

  assign wb.ack   = ack_q;
  assign wb.rdata = rdata_q;
  assign wb.err   = 1'b0;
  assign wb.stall = 1'b0;
  assign txd      = txd_q;
  assign irq      = irq_q;

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      TX_IDLE:  if (!tx_empty) begin tx_pop = 1'b1; tx_next = TX_START; end
      TX_START: if (tx_bound) tx_next = TX_DATA;
      TX_DATA:  if (tx_bound && tx_bits == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_bound) begin
                  if (!tx_empty) begin tx_pop = 1'b1; tx_next = TX_START; end
                  else tx_next = TX_IDLE;
                end
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_shift <= '0;
      tx_bits  <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_next;
      // Timer reloads at every bit boundary, so DIV writes apply from the next bit.
      if (tx_state != TX_IDLE && !tx_bound) tx_timer <= tx_timer - 1'b1;
      else                                  tx_timer <= eff_div - 1'b1;
      if (tx_pop) begin
        tx_shift <= tx_head;
        txd_q    <= 1'b0;
      end else if (tx_state == TX_START && tx_bound) begin
        txd_q    <= tx_shift[0];
        tx_shift <= tx_shift >> 1;
        tx_bits  <= '0;
      end else if (tx_state == TX_DATA && tx_bound) begin
        if (tx_bits == 3'd7) begin
          txd_q <= 1'b1;
        end else begin
          txd_q    <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_bits  <= tx_bits + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rx_next    = rx_state;
    rx_push    = 1'b0;
    rx_ovr_set = 1'b0;
    fe_set     = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_prev & ~rx_s2) rx_next = RX_START;
      RX_START: if (rx_bound) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bound && rx_bits == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_bound) begin
                  rx_next = RX_IDLE;
                  if (rx_s2) begin rx_push = 1'b1; rx_ovr_set = rx_full; end
                  else fe_set = 1'b1;
                end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_timer <= '0;
      rx_shift <= '0;
      rx_bits  <= '0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_next;
      if (rx_state == RX_IDLE)  rx_timer <= (eff_div >> 1) - 1'b1;
      else if (!rx_bound)       rx_timer <= rx_timer - 1'b1;
      else                      rx_timer <= eff_div - 1'b1;
      if (rx_state == RX_START && rx_bound) rx_bits <= '0;
      if (rx_state == RX_DATA && rx_bound) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bits  <= rx_bits + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_uart.sv
// Directed self-checking bench for wb_uart: bus handshake, TX framing, RX, errors, irq.
module tb_wb_uart;
  localparam logic [3:0] A_DATA = 4'h0, A_STATUS = 4'h4, A_DIV = 4'h8, A_CTRL = 4'hC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_drv = 1'b1;
  logic loop = 1'b0;
  logic txd, irq, rxd;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;
  assign rxd = loop ? txd : rxd_drv;

  wb_if bus (.clk(clk), .rst(rst));

  wb_uart #(.FIFO_DEPTH(16), .DIV_WIDTH(16), .DEFAULT_DIV(868)) dut (
    .clk(clk), .rst(rst), .wb(bus), .txd(txd), .rxd(rxd), .irq(irq));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
    bus.adr = {28'h0, a}; bus.sel = s; bus.wdata = d;
    @(posedge clk); #1;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    chk("wr_ack", {31'b0, bus.ack}, 32'd1);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0;
    bus.adr = {28'h0, a}; bus.sel = 4'hF; bus.wdata = '0;
    @(posedge clk); #1;
    bus.cyc = 1'b0; bus.stb = 1'b0;
    chk(tag, bus.rdata, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output logic found);
    found = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (txd === 1'b0) begin found = 1'b1; break; end
    end
  endtask

  // Drives one 8N1 frame at 8 clocks per bit; stop level and length selectable.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (8) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (stop_len) @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       found;
    logic [9:0] frame;
    logic [31:0] exp_st;

    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = '0; bus.sel = '0; bus.wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",   {31'b0, bus.ack},   32'd0);
    chk("rst_err",   {31'b0, bus.err},   32'd0);
    chk("rst_stall", {31'b0, bus.stall}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_txd",   {31'b0, txd}, 32'd1);
    chk("rst_irq",   {31'b0, irq}, 32'd0);
    rst = 1'b0;

    // Ack arrives exactly one cycle after acceptance and lasts one cycle.
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = {28'h0, A_STATUS}; bus.sel = 4'hF;
    chk("ack_before", {31'b0, bus.ack}, 32'd0);
    @(posedge clk); #1;
    bus.cyc = 1'b0; bus.stb = 1'b0;
    chk("ack_one", {31'b0, bus.ack}, 32'd1);
    chk("status_reset", bus.rdata, 32'h2);
    @(posedge clk); #1;
    chk("ack_drop", {31'b0, bus.ack}, 32'd0);
    chk("rdata_idle", bus.rdata, 32'd0);

    // TX framing of 0x55 at DIV=8.
    wr(A_DIV, 32'd8, 4'hF);
    rd(A_DIV, 32'd8, "div_rd8");
    wr(A_DATA, 32'h55, 4'hF);
    wait_start(found);
    chk("tx55_start_seen", {31'b0, found}, 32'd1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int n = 0; n < 80; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      chk("tx55_bit", {31'b0, txd}, {31'b0, frame[n/8]});
    end
    tick(10);

    // DIV below 4 is clamped to 4 clocks per bit.
    wr(A_DIV, 32'd2, 4'hF);
    rd(A_DIV, 32'd2, "div_rd2");
    wr(A_DATA, 32'h01, 4'hF);
    wait_start(found);
    chk("min_div_start_seen", {31'b0, found}, 32'd1);
    for (int n = 0; n < 9; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      chk("min_div_bit", {31'b0, txd}, (n >= 4 && n < 8) ? 32'd1 : 32'd0);
    end
    tick(50);
    wr(A_DIV, 32'd8, 4'hF);

    // Loopback of 0xA3.
    loop = 1'b1;
    wr(A_DATA, 32'hA3, 4'hF);
    tick(3);
    rd(A_STATUS, 32'h22, "status_tx_busy");
    tick(100);
    rd(A_STATUS, 32'h06, "status_rx_valid");
    rd(A_DATA, 32'hA3, "loop_data");
    rd(A_DATA, 32'h0, "empty_read");
    rd(A_STATUS, 32'h02, "status_drained");
    loop = 1'b0;

    // 17 frames into a 16-deep RX FIFO.
    for (int b = 0; b < 17; b++) send_frame(8'(b), 1'b1, 8);
    rd(A_STATUS, 32'h1E, "status_rx_overrun");
    wr(A_STATUS, 32'h10, 4'hF);
    rd(A_STATUS, 32'h0E, "status_overrun_clr");
    for (int b = 0; b < 16; b++) rd(A_DATA, 32'(b), "rx_fifo_order");
    rd(A_STATUS, 32'h02, "status_rx_empty");

    // Framing error and glitch rejection.
    send_frame(8'h5A, 1'b0, 8);
    tick(2);
    rd(A_STATUS, 32'h42, "status_frame_err");
    wr(A_STATUS, 32'h40, 4'hF);
    rd(A_STATUS, 32'h02, "status_fe_clr");
    @(negedge clk); rxd_drv = 1'b0;
    repeat (2) @(negedge clk); rxd_drv = 1'b1;
    tick(30);
    rd(A_STATUS, 32'h02, "status_glitch");

    // 20 back-to-back requests: 18 DATA writes overfill TX, then two STATUS reads.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.sel = 4'hF;
      bus.we  = (i < 18);
      bus.adr = (i < 18) ? {28'h0, A_DATA} : {28'h0, A_STATUS};
      bus.wdata = 32'(i);
      chk("burst_stall", {31'b0, bus.stall}, 32'd0);
      @(posedge clk); #1;
      chk("burst_ack", {31'b0, bus.ack}, 32'd1);
      chk("burst_rdata", bus.rdata, (i >= 18) ? 32'hA1 : 32'h0);
    end
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    @(posedge clk); #1;
    chk("burst_ack_end", {31'b0, bus.ack}, 32'd0);
    chk("txd_midframe", {31'b0, txd}, 32'd0);

    // Reset mid-frame.
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_txd", {31'b0, txd}, 32'd1);
    @(negedge clk); rst = 1'b0;
    rd(A_STATUS, 32'h02, "status_after_rst");
    rd(A_DIV, 32'h364, "div_after_rst");

    // Byte-lane writes into DIV.
    wr(A_DIV, 32'h0000_1234, 4'h1);
    rd(A_DIV, 32'h0334, "div_lane0");
    wr(A_DIV, 32'h0000_AB00, 4'h2);
    rd(A_DIV, 32'hAB34, "div_lane1");
    wr(A_DIV, 32'd8, 4'hF);

    // RX interrupt follows rx_valid by one cycle.
    wr(A_CTRL, 32'h1, 4'hF);
    rd(A_CTRL, 32'h1, "ctrl_rd");
    chk("irq_off", {31'b0, irq}, 32'd0);
    send_frame(8'h3C, 1'b1, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = {28'h0, A_STATUS};
      @(posedge clk); #1;
      exp_st = (i >= 6) ? 32'h06 : 32'h02;
      chk("irq_status", bus.rdata, exp_st);
      chk("irq_level", {31'b0, irq}, (i >= 6) ? 32'd1 : 32'd0);
    end
    bus.cyc = 1'b0; bus.stb = 1'b0;
    rd(A_DATA, 32'h3C, "irq_data");
    tick(1);
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    wr(A_CTRL, 32'h2, 4'hF);
    tick(1);
    chk("irq_tx_empty", {31'b0, irq}, 32'd1);
    wr(A_CTRL, 32'h0, 4'hF);
    tick(1);
    chk("irq_disabled", {31'b0, irq}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_uart.md
Name: wb_uart

Overview:
- Wishbone B4 pipelined slave UART. Sits directly downstream of the shared-bus interconnect as one of its slave ports.
- Provides 8N1 transmit and receive with TX and RX FIFOs, a programmable baud divisor, sticky error flags and a level interrupt.
- Meets the interconnect's fixed timing contract: never stalls, and always acks exactly one cycle after an accepted request.

Parameters:
FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, at least 2
DIV_WIDTH, 16, width of baud divisor register
DEFAULT_DIV, 868, reset divisor in clocks per bit (100 MHz / 115200)

Ports:
clk  input  1  system clock; same net as wb.clk
rst  input  1  reset, synchronous, active-high; same net as wb.rst
wb  interface  -  wb_if.slave; uses cyc, stb, we, adr, sel, write data, read data, ack, err, stall
txd  output  1  serial transmit, idle high
rxd  input  1  serial receive, asynchronous to clk
irq  output  1  level interrupt, registered

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - outputs: ack=0, err=0, stall=0, read data=0, txd=1, irq=0
  - internal: both FIFOs empty, DIV=DEFAULT_DIV, CTRL=0, sticky flags 0, TX FSM and RX FSM in IDLE
- Reset asserted mid-frame: txd=1 on the next cycle; FIFO contents are discarded.
- Bus handshake:
  - Request accepted when cyc & stb; stall is tied 0.
  - ack=1 in the cycle after acceptance, for exactly 1 cycle; back-to-back requests give back-to-back acks.
  - err is always 0.
  - Read data is registered with ack and is 0 whenever ack=0.
- Register map, decoded on adr[3:2]:
  - 0x0 DATA
    - Write with sel[0]=1: push dat[7:0] to TX FIFO. If TX full (state at start of cycle), the byte is dropped and tx_ovf is set.
    - Read: returns {24'b0, RX head} and pops. If RX is empty, returns 0 and does not pop.
  - 0x4 STATUS
    - Bits: 0 tx_full, 1 tx_empty, 2 rx_valid, 3 rx_full, 4 rx_overrun, 5 tx_busy, 6 frame_err, 7 tx_ovf.
    - Bits 4, 6 and 7 are sticky, write-1-to-clear. Other bits are read-only.
  - 0x8 DIV: bits [DIV_WIDTH-1:0], byte-lane writes per sel. Effective divisor = max(DIV, 4).
  - 0xC CTRL: bit0 rx_irq_en, bit1 tx_irq_en. Other bits read 0.
- Simultaneous events:
  - RX push and bus pop in the same cycle: both occur, count unchanged.
  - A sticky set and its W1C in the same cycle: the set wins.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: when TX FIFO is non-empty, pop and go to START.
  - Each state holds for the effective divisor number of clocks (bit timer counts down to 0).
  - DATA shifts 8 bits, LSB first. STOP drives 1, then returns to IDLE, or goes directly to START if FIFO is non-empty (no idle gap).
  - tx_busy=1 whenever not in IDLE.
  - A DIV change takes effect at the next bit boundary.
- RX path:
  - rxd passes through a 2-flop synchronizer.
  - RX FSM (IDLE, START, DATA, STOP):
    - IDLE: a falling edge moves to START.
    - START: after floor(div/2) clocks, sample; if 1, it is a false start and returns to IDLE.
    - DATA: 8 samples at div spacing.
    - STOP: sample at div spacing.
  - Stop sample=0: set frame_err, discard the byte.
  - Stop sample=1: push the byte; if RX is full, drop it and set rx_overrun.
  - Return to IDLE immediately after the stop sample.
- irq (registered, 1-cycle latency): irq <= (rx_irq_en & rx_valid) | (tx_irq_en & tx_empty & ~tx_busy).

Decomposition:
- Package wb_uart_pkg:
  - register offset constants
  - STATUS bit index constants
  - tx_state_t and rx_state_t enums
  - default divisor constant
- One sub-module, sync_fifo (parameters WIDTH, DEPTH):
  - ports: push, pop, wdata, rdata (head, combinational), full, empty
  - behaviour: push ignored when full, pop ignored when empty, pointers wrap modulo DEPTH
  - instantiated twice, for TX and RX.

Test Plan:
1. Reset, then read STATUS -> ack 1 cycle later, data 0x00000002; txd=1; irq=0.
2. Write DIV=8, write DATA 0x55 -> txd start 0 for 8 clocks, then bits 1,0,1,0,1,0,1,0 at 8 clocks each, stop 1; frame is 80 clocks; tx_busy=1 throughout.
3. Loopback rxd=txd, DIV=8, send 0xA3 -> after stop bit, STATUS bit2=1. Read DATA returns 0x000000A3; the next read returns 0 and STATUS bit2=0.
4. DIV=8, inject 17 frames 0x00..0x10 with no reads -> rx_full=1, rx_overrun=1. Write STATUS 0x10 clears bit4. 16 reads return 0x00..0x0F.
5. Inject a frame with stop bit 0 -> frame_err=1, rx_valid stays 0. Inject a 2-clock low glitch -> no push, no error.
6. 20 consecutive cycles of cyc&stb with mixed reads and writes -> stall=0 always, ack in each following cycle. CTRL=1 with a received byte -> irq=1 one cycle after rx_valid=1.
